// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, constants and buffer entry type for the dual fetch unit
package fetch_pkg;

  localparam int                 INSTR_W          = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0]        DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular instruction buffer, up to two pushes and two pops per cycle, with flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               push_cnt,
  input  fetch_entry_t             push_tdata0,
  input  fetch_entry_t             push_tdata1,
  input  logic [1:0]               pop_cnt,
  output fetch_entry_t             head0,
  output fetch_entry_t             head1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr1;
  logic [PTR_W-1:0] wr_ptr1;
  logic [1:0]       pop_eff;

  assign rd_ptr1 = rd_ptr + PTR_W'(1);
  assign wr_ptr1 = wr_ptr + PTR_W'(1);

  // never pop past what is stored, so the count cannot underflow
  always_comb begin
    pop_eff = pop_cnt;
    if (CNT_W'(pop_cnt) > count) pop_eff = count[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_eff);
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      count  <= count + CNT_W'(push_cnt) - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (push_cnt != 2'd0) mem[wr_ptr]  <= push_tdata0;
      if (push_cnt == 2'd2) mem[wr_ptr1] <= push_tdata1;
    end
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr1];

endmodule

// File: rtl/fetch_dual.sv
// rtl/fetch_dual.sv - dual-wide fetch: PC, request and squash control around fetch_fifo
// FETCH_PERF_EN adds a saturating counter of starved, unstalled decode cycles on perf_bubbles.
module fetch_dual
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 8
) (
  input  logic               reloj,
  input  logic               reset,
  output logic               imem_rd_en,
  output logic [31:0]        imem_addr,
  input  logic [63:0]        imem_data,
  input  logic               dec_stall,
  output logic [INSTR_W-1:0] inst1,
  output logic [INSTR_W-1:0] inst2,
  output logic               valid1,
  output logic               valid2,
  output logic [3:0]         pc_4,
  output logic [3:0]         pc_8,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        perf_bubbles
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      fetch_pc;
  logic             skip_lo;
  logic             inflight;
  logic             inflight_skip;
  logic [31:0]      inflight_pc;
  logic [CNT_W-1:0] count;
  logic [1:0]       push_cnt;
  logic [1:0]       pop_cnt;
  logic             room;
  fetch_entry_t     push0;
  fetch_entry_t     push1;
  fetch_entry_t     head0;
  fetch_entry_t     head1;
  logic             unused_bits;

  // an outstanding response will land two entries, so reserve them before asking again
  assign room       = (DEPTH - int'(count) - (inflight ? 2 : 0)) >= 2;
  assign imem_rd_en = !reset && !redirect && room;
  assign imem_addr  = fetch_pc;

  always_comb begin
    push_cnt    = 2'd0;
    push1.instr = imem_data[63:32];
    push1.pc    = inflight_pc + 32'd4;
    push0.instr = imem_data[31:0];
    push0.pc    = inflight_pc;
    if (inflight && !redirect) begin
      if (inflight_skip) begin
        push_cnt = 2'd1;
        push0    = push1;
      end else begin
        push_cnt = 2'd2;
      end
    end
  end

  always_comb begin
    pop_cnt = 2'd0;
    if (!dec_stall && !redirect) begin
      if (count >= CNT_W'(2))     pop_cnt = 2'd2;
      else if (count != '0)       pop_cnt = 2'd1;
    end
  end

  // fetch_pc is always pair aligned; skip_lo marks a word-4 entry point
  always_ff @(posedge reloj) begin
    if (reset) begin
      fetch_pc      <= {RESET_PC[31:3], 3'b000};
      skip_lo       <= RESET_PC[2];
      inflight      <= 1'b0;
      inflight_skip <= 1'b0;
      inflight_pc   <= '0;
    end else begin
      inflight <= imem_rd_en;
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:3], 3'b000};
        skip_lo  <= redirect_pc[2];
      end else if (imem_rd_en) begin
        fetch_pc      <= fetch_pc + 32'd8;
        skip_lo       <= 1'b0;
        inflight_pc   <= fetch_pc;
        inflight_skip <= skip_lo;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (reloj),
    .reset       (reset),
    .flush       (redirect),
    .push_cnt    (push_cnt),
    .push_tdata0 (push0),
    .push_tdata1 (push1),
    .pop_cnt     (pop_cnt),
    .head0       (head0),
    .head1       (head1),
    .count       (count)
  );

  assign valid1 = count != '0;
  assign valid2 = count >= CNT_W'(2);
  assign inst1  = valid1 ? head0.instr : NOP_INSTR;
  assign inst2  = valid2 ? head1.instr : NOP_INSTR;
  assign pc_4   = valid1 ? head0.pc[31:28] : 4'h0;
  assign pc_8   = valid2 ? head1.pc[31:28] : 4'h0;

  assign unused_bits = ^{redirect_pc[1:0], head0.pc[27:0], head1.pc[27:0]};

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt;

  always_ff @(posedge reloj) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (!dec_stall && !redirect && !valid1 && bubble_cnt != 32'hFFFF_FFFF) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign perf_bubbles = bubble_cnt;
`else
  assign perf_bubbles = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_dual.sv
// tb/tb_fetch_dual.sv - directed plus randomized bench for fetch_dual against a queue-based model
module tb_fetch_dual;
  import fetch_pkg::*;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        reloj = 1'b0;
  logic        reset;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [63:0] imem_data;
  logic        dec_stall;
  logic [31:0] inst1;
  logic [31:0] inst2;
  logic        valid1;
  logic        valid2;
  logic [3:0]  pc_4;
  logic [3:0]  pc_8;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] perf_bubbles;

  fetch_dual #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .reloj        (reloj),
    .reset        (reset),
    .imem_rd_en   (imem_rd_en),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .dec_stall    (dec_stall),
    .inst1        (inst1),
    .inst2        (inst2),
    .valid1       (valid1),
    .valid2       (valid2),
    .pc_4         (pc_4),
    .pc_8         (pc_8),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .perf_bubbles (perf_bubbles)
  );

  always #5 reloj = ~reloj;

  int           n_pass  = 0;
  int           n_total = 0;
  fetch_entry_t q[$];
  logic [31:0]  m_pc;
  logic         m_skip;
  logic         m_fl;
  logic         m_fl_skip;
  logic [31:0]  m_fl_pc;
  logic [31:0]  m_bubbles;
  logic         m_known;
  logic         mem_pend;
  logic [31:0]  mem_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // one clock cycle: drive, check against the model, then advance the model
  task automatic step(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc);
    logic         exp_rd;
    logic         bub;
    fetch_entry_t h0;
    fetch_entry_t h1;
    fetch_entry_t e;
    reset       = rst;
    dec_stall   = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    imem_data   = (mem_pend === 1'b1) ? {memf(mem_addr + 32'd4), memf(mem_addr)}
                                      : {$urandom, $urandom};
    #3;
    exp_rd = !rst && !rdr && ((DEPTH - q.size() - (m_fl ? 2 : 0)) >= 2);
    h0 = '0;
    h1 = '0;
    h0.instr = NOP_INSTR;
    h1.instr = NOP_INSTR;
    if (q.size() > 0) h0 = q[0];
    if (q.size() > 1) h1 = q[1];
    if (m_known) begin
      chk("valid1", 32'(valid1), 32'(q.size() >= 1));
      chk("valid2", 32'(valid2), 32'(q.size() >= 2));
      chk("inst1", inst1, h0.instr);
      chk("inst2", inst2, h1.instr);
      chk("pc_4", 32'(pc_4), 32'(h0.pc[31:28]));
      chk("pc_8", 32'(pc_8), 32'(h1.pc[31:28]));
      chk("imem_rd_en", 32'(imem_rd_en), 32'(exp_rd));
      if (exp_rd) chk("imem_addr", imem_addr, m_pc);
`ifdef FETCH_PERF_EN
      chk("perf_bubbles", perf_bubbles, m_bubbles);
`else
      chk("perf_bubbles", perf_bubbles, 32'h0);
`endif
    end
    bub = !stl && !rdr && (q.size() == 0);
    if (rst) begin
      q.delete();
      m_pc      = {RESET_PC[31:3], 3'b000};
      m_skip    = RESET_PC[2];
      m_fl      = 1'b0;
      m_bubbles = '0;
      m_known   = 1'b1;
    end else if (rdr) begin
      q.delete();
      m_pc   = {rpc[31:3], 3'b000};
      m_skip = rpc[2];
      m_fl   = 1'b0;
    end else begin
      if (!stl) for (int k = 0; k < 2 && q.size() > 0; k++) void'(q.pop_front());
      if (m_fl) begin
        if (!m_fl_skip) begin
          e.instr = memf(m_fl_pc);
          e.pc    = m_fl_pc;
          q.push_back(e);
        end
        e.instr = memf(m_fl_pc + 32'd4);
        e.pc    = m_fl_pc + 32'd4;
        q.push_back(e);
      end
      m_fl = exp_rd;
      if (exp_rd) begin
        m_fl_pc   = m_pc;
        m_fl_skip = m_skip;
        m_skip    = 1'b0;
        m_pc      = m_pc + 32'd8;
      end
      if (bub && m_bubbles != 32'hFFFF_FFFF) m_bubbles = m_bubbles + 32'd1;
    end
    mem_pend = imem_rd_en;
    mem_addr = imem_addr;
    @(posedge reloj);
    #1;
  endtask

  initial begin
    m_known   = 1'b0;
    mem_pend  = 1'b0;
    mem_addr  = '0;
    m_bubbles = '0;
    m_fl      = 1'b0;
    m_fl_skip = 1'b0;
    m_fl_pc   = '0;
    m_skip    = 1'b0;
    m_pc      = '0;

    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    #2 chk("reset_valid1", 32'(valid1), 32'h0);
    chk("reset_inst1", inst1, 32'h0);
    chk("reset_perf", perf_bubbles, 32'h0);

    // startup: pairs at 0, 8, 0x10; both slots valid two cycles after release
    step(1'b0, 1'b0, 1'b0, 32'h0);
    #2 chk("start_valid1_early", 32'(valid1), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    #2 chk("start_valid2", 32'(valid2), 32'h1);
    chk("start_inst1", inst1, memf(32'h0));
    chk("start_inst2", inst2, memf(32'h4));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    // long stall fills the buffer to DEPTH, then drains in order
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    // unaligned redirect with a response in flight
    step(1'b0, 1'b0, 1'b1, 32'h1000_0004);
    #2 chk("redir_valid1", 32'(valid1), 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    #2 chk("redir_pc_4", 32'(pc_4), 32'h1);
    chk("redir_inst1", inst1, memf(32'h1000_0004));
    chk("redir_valid2", 32'(valid2), 32'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    // one-cycle reset mid-stream
    step(1'b1, 1'b0, 1'b0, 32'h0);
    #2 chk("midreset_valid1", 32'(valid1), 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    // fetch PC wraps past the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0);
    for (int i = 0; i < 6; i++) step(1'b0, (i % 2) == 1, 1'b0, 32'h0);

    // randomized traffic: stalls, redirects (often odd targets), rare resets
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0, $urandom);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_dual.md
FETCH_DUAL -- requirements
Module: fetch_dual

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 8, instruction-buffer slots; power of two, >= 4.
REQ-003 SHALL have one clock and a synchronous, active-high reset: reloj and reset.
REQ-004 Ports (direction, width, meaning):
- reloj, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- imem_rd_en, out, 1, fetch request.
- imem_addr, out, 32, 8-byte-aligned pair address.
- imem_data, in, 64, [31:0] = instr at addr, [63:32] = instr at addr+4; valid exactly 1 cycle after request.
- dec_stall, in, 1, decode not accepting this cycle.
- inst1, out, 32, oldest instruction.
- inst2, out, 32, next instruction.
- valid1, out, 1, inst1 valid.
- valid2, out, 1, inst2 valid.
- pc_4, out, 4, PC[31:28] of inst1.
- pc_8, out, 4, PC[31:28] of inst2.
- redirect, in, 1, taken branch/jump.
- redirect_pc, in, 32, target; bits [1:0] ignored.
- perf_bubbles, out, 32, see Configuration.

Function
REQ-005 SHALL buffer fetched instructions FIFO-ordered, each with its 32-bit PC.
REQ-006 SHALL assert imem_rd_en when (free slots - 2 x in-flight) >= 2 and no redirect this cycle; fetch PC advances +8 per request.
REQ-007 SHALL push both halves of imem_data one cycle after a request, unless the request was squashed.
REQ-008 Unaligned redirect target (bit 2 set) SHALL fetch the pair at target & ~7 and push only [63:32].
REQ-009 valid1 = count>=1, valid2 = count>=2; inst/pc outputs come from the buffer head combinationally; an invalid slot outputs 32'h0 (NOP).
REQ-010 When dec_stall=0, SHALL pop min(count,2) entries; when dec_stall=1, SHALL pop none.
REQ-011 Push and pop in the same cycle SHALL both take effect; the count never exceeds DEPTH and never goes negative.
REQ-012 redirect=1 SHALL, in one cycle, empty the buffer, squash any in-flight response, and set fetch PC to redirect_pc; valid1/valid2 are 0 the next cycle.
REQ-013 redirect overrides dec_stall and any same-cycle push.
REQ-014 Buffer pointers SHALL wrap modulo DEPTH with no data loss across the wrap boundary.
REQ-015 Fetch PC wraps 32'hFFFF_FFF8 -> 32'h0000_0000.

Reset
REQ-016 On reset, the following SHALL apply next cycle:
- fetch PC = RESET_PC; count = 0.
- in-flight cleared; imem_rd_en = 0; valid1 = valid2 = 0; inst1 = inst2 = 0.
- pc_4 = pc_8 = 0; perf_bubbles = 0.
REQ-017 Reset asserted mid-operation SHALL discard the buffer and any response arriving the following cycle.
REQ-018 The first request SHALL issue on the first cycle after reset deasserts, at imem_addr = RESET_PC.

Configuration
REQ-019 With FETCH_PERF_EN defined, perf_bubbles SHALL count cycles where dec_stall=0, redirect=0 and valid1=0, saturating at 32'hFFFF_FFFF.
REQ-020 Without FETCH_PERF_EN, perf_bubbles SHALL be tied to 32'h0 and no counter logic SHALL exist.

Structure
REQ-021 Package fetch_pkg SHALL hold INSTR_W=32, NOP_INSTR=32'h0, the default RESET_PC, and a typedef for buffer entries (instr + pc).
REQ-022 Sub-module fetch_fifo SHALL implement the 2-wide push / 2-wide pop circular buffer with flush; fetch_dual holds the PC, request and squash logic.

Verification
REQ-023 Reset, then memory returns pairs, dec_stall=0 -> requests at 0x0, 0x8, 0x10 on consecutive cycles; first valid1=valid2=1 two cycles after reset release.
REQ-024 dec_stall=1 held for 10 cycles -> requests stop once count reaches DEPTH-2 with one in flight; count peaks at exactly 8; no instruction lost or duplicated after release.
REQ-025 redirect with redirect_pc=0x1000_0004 while a request is in flight -> old response dropped; next pushed entry is PC 0x1000_0004 alone; pc_4=4'h1.
REQ-026 Force the buffer to wrap with count=1 on pop-1/push-2 cycles -> output order matches PC order across the pointer wrap.
REQ-027 Reset asserted for 1 cycle mid-stream -> valid1=0 next cycle; next imem_addr=RESET_PC; late response ignored.
REQ-028 FETCH_PERF_EN defined, 5 starved unstalled cycles after a redirect -> perf_bubbles=5; undefined -> perf_bubbles=0.
